serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 15 +
 rtl/serial_subtractor.sv | 91 +++++++++
 tb/tb_serial_subtractor.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake and operand/result bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, LSB first, one full-subtractor cell and a registered borrow
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH:0]   w_sd_ext;
  logic [WIDTH-1:0] w_sd_next;

  assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_bo      = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  // Concatenate then drop the LSB so the shift also works for WIDTH=1.
  assign w_sd_ext  = {w_d, r_sd};
  assign w_sd_next = w_sd_ext[WIDTH:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sd     <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sd  <= w_sd_next;
          r_br  <= w_bo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_diff   <= w_sd_next;
            r_borrow <= w_bo;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1
module tb_serial_subtractor;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  typedef struct packed {
    logic       borrow;
    logic [7:0] diff;
  } exp8_t;
  typedef struct packed {
    logic borrow;
    logic diff;
  } exp1_t;

  exp8_t q8[$];
  exp1_t q1[$];

  serial_subtractor_if #(.WIDTH(8)) i8 ();
  serial_subtractor_if #(.WIDTH(1)) i1 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  serial_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the first negedge after the accepting edge.
  task automatic wait_done8(input string tag);
    int    nbusy;
    exp8_t e;
    nbusy = 0;
    for (int c = 0; c < 20 && i8.done !== 1'b1; c++) begin
      if (i8.busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(i8.done), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    chk({tag, "_busy_at_done"}, 32'(i8.busy), 32'd0);
    e = q8.pop_front();
    chk({tag, "_diff"}, 32'(i8.diff), 32'(e.diff));
    chk({tag, "_borrow"}, 32'(i8.borrow), 32'(e.borrow));
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    @(negedge clk);
    i8.a = a; i8.b = b; i8.start = 1'b1;
    r = {1'b0, a} - {1'b0, b};
    q8.push_back('{borrow: r[8], diff: r[7:0]});
    @(negedge clk);
    i8.start = 1'b0;
    wait_done8(tag);
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(i8.done), 32'd0);
  endtask

  task automatic op1(input string tag, input logic a, input logic b);
    logic [1:0] r;
    exp1_t      e;
    int         n;
    @(negedge clk);
    i1.a = a; i1.b = b; i1.start = 1'b1;
    r = {1'b0, a} - {1'b0, b};
    q1.push_back('{borrow: r[1], diff: r[0]});
    @(negedge clk);
    i1.start = 1'b0;
    chk({tag, "_busy"}, 32'(i1.busy), 32'd1);
    n = 0;
    for (int c = 0; c < 10 && i1.done !== 1'b1; c++) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(n), 32'd1);
    e = q1.pop_front();
    chk({tag, "_diff"}, 32'(i1.diff), 32'(e.diff));
    chk({tag, "_borrow"}, 32'(i1.borrow), 32'(e.borrow));
  endtask

  initial begin
    logic [8:0] r;
    exp8_t      e;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    i8.start = 1'b0; i8.a = '0; i8.b = '0;
    i1.start = 1'b0; i1.a = '0; i1.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(i8.busy), 32'd0);
    chk("rst_done", 32'(i8.done), 32'd0);
    chk("rst_diff", 32'(i8.diff), 32'd0);
    chk("rst_borrow", 32'(i8.borrow), 32'd0);
    chk("rst_w1_diff", 32'(i1.diff), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op8("t35_12", 8'h35, 8'h12);
    op8("t12_35", 8'h12, 8'h35);
    op8("t00_01", 8'h00, 8'h01);
    op8("tff_ff", 8'hFF, 8'hFF);
    op8("t80_7f", 8'h80, 8'h7F);

    // start held high with operands churning through RUN, then back-to-back accept.
    @(negedge clk);
    i8.a = 8'h40; i8.b = 8'h01; i8.start = 1'b1;
    q8.push_back('{borrow: 1'b0, diff: 8'h3F});
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("b2b_run_busy", 32'(i8.busy), 32'd1);
      chk("b2b_run_hold", 32'(i8.diff), 32'h01);
      i8.a = 8'($urandom); i8.b = 8'($urandom);
    end
    @(negedge clk);
    chk("b2b_first_done", 32'(i8.done), 32'd1);
    e = q8.pop_front();
    chk("b2b_first_diff", 32'(i8.diff), 32'(e.diff));
    chk("b2b_first_borrow", 32'(i8.borrow), 32'(e.borrow));
    i8.a = 8'hA5; i8.b = 8'h5A;
    r = {1'b0, 8'hA5} - {1'b0, 8'h5A};
    q8.push_back('{borrow: r[8], diff: r[7:0]});
    @(negedge clk);
    i8.start = 1'b0;
    chk("b2b_second_done_low", 32'(i8.done), 32'd0);
    chk("b2b_second_busy", 32'(i8.busy), 32'd1);
    chk("b2b_second_hold", 32'(i8.diff), 32'h3F);
    wait_done8("b2b_second");

    // Asynchronous reset after four RUN edges.
    @(negedge clk);
    i8.a = 8'h77; i8.b = 8'h11; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(i8.busy), 32'd0);
    chk("arst_done", 32'(i8.done), 32'd0);
    chk("arst_diff", 32'(i8.diff), 32'd0);
    chk("arst_borrow", 32'(i8.borrow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("arst_no_done", 32'(i8.done), 32'd0);
    end
    op8("t10_20", 8'h10, 8'h20);

    op1("w1_00", 1'b0, 1'b0);
    op1("w1_01", 1'b0, 1'b1);
    op1("w1_10", 1'b1, 1'b0);
    op1("w1_11", 1'b1, 1'b1);

    chk("q8_empty", 32'(q8.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
